upload_sched: RTL and testbench
===============================

# upload_sched

Job scheduler that shares the single RAM/register-to-PC UART uploader between four host requesters: test echo, CPS/sample-count readout, setting readout and correlation-function dump. It queues request pulses as pending bits, grants them round-robin, expands each grant into one or more (startAddr, endAddr, source) upload jobs, and paces each job on the uploader's completion strobe. A watchdog aborts a job if completion never arrives. It sits between the host command decoder and the uploader/data-mux.

## Interface
- TO_W, default 24: watchdog counter width; a timeout fires after 2^TO_W-1 cycles in WAIT.
- clk  in  1  50 MHz system clock
- rst_n  in  1  reset, asynchronous, active-low
- reqTest / reqCps / reqSetting / reqCF  in  1 each  single-cycle request pulses (requesters 0..3)
- sendOk  in  1  uploader job-complete strobe
- clrErr  in  1  clears timeoutErr
- sendSig  out  1  one-cycle job start to the uploader
- startAddr / endAddr  out  16 each  inclusive word range of the current job
- srcSel  out  2  data-mux select: 0 = constant "OK\r", 1 = cps/sampleCnt regs, 2 = setting regs, 3 = CF RAM
- busy  out  1  high in every state except IDLE
- pendMask  out  4  pending bits, bit n = requester n
- timeoutErr  out  1  sticky watchdog flag

## Operation
- Pending: bit n set on the edge that samples reqN high; cleared on the edge leaving ARB with grant n. If set and clear coincide, set wins, so the requester is serviced again later. A request while its bit is already set is absorbed (coalesced).
- Arbitration: round-robin over pendMask, starting at requester (lastGrant+1) mod 4. lastGrant resets to 3, so requester 0 wins first.
- Job table:
  - Test: 0x0000–0x0000, srcSel 0.
  - Cps: 0x0010–0x0011, srcSel 1.
  - Setting: 0x0020–0x0023, srcSel 2.
  - CF: 5 segments, all srcSel 3, issued back-to-back and not pre-emptible: 0x1000–0x101F, 0x2000–0x203F, 0x3000–0x307F, 0x4000–0x40FF, 0x5000–0x51FF.
- Segment counter seg, 3 bits: 0 on ARB; incremented in NEXT.
- State machine:
  - IDLE: pendMask≠0 → ARB.
  - ARB: latch grant, clear pending bit, seg=0 → LOAD.
  - LOAD: register startAddr/endAddr/srcSel from grant and seg → SEND.
  - SEND: sendSig=1, clear watchdog → WAIT.
  - WAIT:
    - sendOk → NEXT.
    - Watchdog reaches 2^TO_W-1 → set timeoutErr → IDLE. Remaining CF segments are dropped.
  - NEXT: grant==CF and seg<4 → seg+1, LOAD; otherwise → IDLE.
  - Undefined encodings → IDLE.
- sendOk outside WAIT is ignored.
- clrErr clears timeoutErr. If clrErr and a timeout occur in the same cycle, the set wins.
- startAddr/endAddr/srcSel hold their values between jobs; the downstream data mux keys off them.

## Timing
- Reset values: state IDLE; sendSig 0; startAddr 0; endAddr 0; srcSel 0; busy 0; pendMask 0; timeoutErr 0; lastGrant 3; seg 0.
- Request pulse sampled at edge E:
  - pendMask visible after E.
  - ARB in cycle E+1.
  - LOAD in E+2.
  - sendSig high for exactly the cycle after edge E+3.
  - Total: 4 cycles from sampling edge to start pulse when idle.
- Addresses are stable one full cycle before sendSig and throughout WAIT.
- sendOk sampled at edge K:
  - NEXT in the following cycle.
  - Next segment's sendSig 3 cycles after K (NEXT, LOAD, SEND).
  - Return to IDLE when the job is finished; the next grant's sendSig follows 4 cycles after NEXT.
- Reset mid-job drops all pending bits and the in-flight job immediately; sendSig never glitches high during reset.

## Test plan
- Single reqTest: sendSig 4 cycles later with start=end=0x0000, srcSel 0. Return sendOk after 10 cycles → busy falls 2 cycles later; pendMask=0.
- reqCF, uploader acking each job after 5 cycles: exactly 5 sendSig pulses with ranges 0x1000/0x101F … 0x5000/0x51FF in order, all srcSel 3. Pulses spaced 5+3 cycles.
- reqTest, reqCps, reqSetting and reqCF in the same cycle: grant order 0,1,2,3. Then re-request all four during the CF dump: next order 0,1,2,3 again (pointer after CF wraps to 0).
- reqCps pulsed 3 times while a Setting job is in WAIT: one Cps job only. A reqCps coincident with Cps's ARB cycle re-pends it: two Cps jobs total.
- TO_W=4, no sendOk during the CF dump: timeoutErr=1 after 15 WAIT cycles; return to IDLE with seg-1..4 not issued. clrErr clears the flag; a subsequent reqTest is serviced normally.
- Assert rst_n low during WAIT of CF segment 2: all outputs at reset values asynchronously. After release, no sendSig until a new request arrives.

Source files
------------

// File: rtl/upload_sched.sv
// upload_sched: shares one RAM/register-to-UART uploader between four host
// requesters. Requests are queued as pending bits, granted round-robin, and
// each grant is expanded into one or more (startAddr, endAddr, srcSel) jobs
// that are paced on the uploader's sendOk strobe and guarded by a watchdog.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a pending bit
// ARB   | pick next requester round-robin, clear its pending bit, seg = 0
// LOAD  | job range/source registered (loaded on entry), settling
// SEND  | one-cycle sendSig, watchdog reloaded
// WAIT  | waiting for sendOk or watchdog terminal count
// NEXT  | CF grant with segments left -> LOAD, otherwise -> IDLE
module upload_sched #(
  parameter int TO_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqTest,
  input  logic        reqCps,
  input  logic        reqSetting,
  input  logic        reqCF,
  input  logic        sendOk,
  input  logic        clrErr,
  output logic        sendSig,
  output logic [15:0] startAddr,
  output logic [15:0] endAddr,
  output logic [1:0]  srcSel,
  output logic        busy,
  output logic [3:0]  pendMask,
  output logic        timeoutErr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_LOAD = 3'd2,
    S_SEND = 3'd3,
    S_WAIT = 3'd4,
    S_NEXT = 3'd5
  } state_t;

  localparam logic [1:0]      GRANT_CF = 2'd3;
  localparam logic [2:0]      SEG_LAST = 3'd4;
  localparam logic [TO_W-1:0] WD_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [3:0]      pend_q;
  logic [3:0]      req_vec;
  logic [3:0]      pend_clr;
  logic [1:0]      grant_q;
  logic [1:0]      arb_pick;
  logic [1:0]      cand;
  logic [2:0]      seg_q;
  logic [TO_W-1:0] wd_q;
  logic            timeout_hit;
  logic [1:0]      job_grant;
  logic [2:0]      job_seg;
  logic [2:0]      job_seg_p1;
  logic [15:0]     job_start;
  logic [15:0]     job_end;

  assign req_vec  = {reqCF, reqSetting, reqCps, reqTest};
  assign pendMask = pend_q;
  // Watchdog counts down from all-ones; reaching 1 in WAIT marks 2^TO_W-1 WAIT cycles.
  assign timeout_hit = (state_q == S_WAIT) && !sendOk && (wd_q == WD_ONE);
  assign pend_clr    = (state_q == S_ARB) ? (4'b0001 << arb_pick) : 4'b0000;

  // Round-robin pick: first pending requester after the last grant.
  always_comb begin
    arb_pick = grant_q;
    cand     = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      cand = grant_q + 2'(i);
      if (pend_q[cand]) arb_pick = cand;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_d = state_q;
    sendSig = 1'b0;
    busy    = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (|pend_q) state_d = S_ARB;
      end
      S_ARB:  state_d = S_LOAD;
      S_LOAD: state_d = S_SEND;
      S_SEND: begin
        sendSig = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sendOk)           state_d = S_NEXT;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_NEXT: begin
        if (grant_q == GRANT_CF && seg_q < SEG_LAST) state_d = S_LOAD;
        else                                         state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job table lookup; in ARB it looks ahead at the fresh pick so the range
  // registers load on entry to LOAD and are settled a full cycle before sendSig.
  always_comb begin
    job_grant = grant_q;
    job_seg   = seg_q + 3'd1;
    if (state_q == S_ARB) begin
      job_grant = arb_pick;
      job_seg   = 3'd0;
    end
    job_seg_p1 = job_seg + 3'd1;
    case (job_grant)
      2'd0: begin job_start = 16'h0000; job_end = 16'h0000; end
      2'd1: begin job_start = 16'h0010; job_end = 16'h0011; end
      2'd2: begin job_start = 16'h0020; job_end = 16'h0023; end
      default: begin
        // CF segment s covers 0x(s+1)000 for 32<<s words.
        job_start = {1'b0, job_seg_p1, 12'h000};
        job_end   = job_start + ((16'd32 << job_seg) - 16'd1);
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Pending bits: a new request wins over the ARB clear so it is serviced again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 4'b0000;
    else        pend_q <= (pend_q & ~pend_clr) | req_vec;
  end

  // Grant (doubles as round-robin pointer) and CF segment counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= 2'd3;
      seg_q   <= 3'd0;
    end else if (state_q == S_ARB) begin
      grant_q <= arb_pick;
      seg_q   <= 3'd0;
    end else if (state_q == S_NEXT && state_d == S_LOAD) begin
      seg_q   <= seg_q + 3'd1;
    end
  end

  // Watchdog down-counter, reloaded at every job start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wd_q <= '1;
    else if (state_q == S_SEND)                 wd_q <= '1;
    else if (state_q == S_WAIT && !timeout_hit) wd_q <= wd_q - WD_ONE;
  end

  // Job range/source registers; hold between jobs for the downstream mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startAddr <= 16'h0000;
      endAddr   <= 16'h0000;
      srcSel    <= 2'd0;
    end else if (state_d == S_LOAD) begin
      startAddr <= job_start;
      endAddr   <= job_end;
      srcSel    <= job_grant;
    end
  end

  // Sticky timeout flag; a timeout in the same cycle as clrErr keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           timeoutErr <= 1'b0;
    else if (timeout_hit) timeoutErr <= 1'b1;
    else if (clrErr)      timeoutErr <= 1'b0;
  end

endmodule

// File: tb/tb_upload_sched.sv
// Testbench for upload_sched: scenario tasks with a behavioural job/round-robin model.
module tb_upload_sched;

  localparam int TO_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqTest, reqCps, reqSetting, reqCF, sendOk, clrErr;
  logic        sendSig;
  logic [15:0] startAddr, endAddr;
  logic [1:0]  srcSel;
  logic        busy;
  logic [3:0]  pendMask;
  logic        timeoutErr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_last = 3;
  logic [33:0] obs_q[$];
  logic [33:0] exp_q[$];
  int          obs_t[$];

  upload_sched #(.TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqTest(reqTest), .reqCps(reqCps), .reqSetting(reqSetting), .reqCF(reqCF),
    .sendOk(sendOk), .clrErr(clrErr),
    .sendSig(sendSig), .startAddr(startAddr), .endAddr(endAddr), .srcSel(srcSel),
    .busy(busy), .pendMask(pendMask), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation ran past 500000 ns, want finish");
    $fatal(1);
  end

  task automatic set_req(input logic [3:0] m);
    {reqCF, reqSetting, reqCps, reqTest} = m;
  endtask

  // Reference job list for one grant, straight from the job table.
  function automatic void model_push(input int r);
    case (r)
      0: exp_q.push_back({16'h0000, 16'h0000, 2'd0});
      1: exp_q.push_back({16'h0010, 16'h0011, 2'd1});
      2: exp_q.push_back({16'h0020, 16'h0023, 2'd2});
      default:
        for (int s = 0; s < 5; s++) begin
          int st;
          int ln;
          st = (s + 1) * 4096;
          ln = 32 * (1 << s);
          exp_q.push_back({16'(st), 16'(st + ln - 1), 2'd3});
        end
    endcase
  endfunction

  function automatic int rr_pick(input logic [3:0] p, input int last);
    for (int k = 1; k <= 4; k++) begin
      int r;
      r = (last + k) % 4;
      if (p[r]) return r;
    end
    return -1;
  endfunction

  // All bits of m pending at once: service them in round-robin order.
  function automatic void model_batch(input logic [3:0] m);
    logic [3:0] p;
    int g;
    p = m;
    while (p != 4'b0000) begin
      g = rr_pick(p, model_last);
      p[g] = 1'b0;
      model_last = g;
      model_push(g);
    end
  endfunction

  task automatic clear_q();
    obs_q.delete();
    exp_q.delete();
    obs_t.delete();
  endtask

  task automatic pulse(input logic [3:0] m);
    set_req(m);
    @(negedge clk);
    set_req(4'b0000);
  endtask

  // Uploader stand-in: captures each job, acks after a random delay,
  // optionally pulsing requests during job inj_job's WAIT.
  task automatic serve(input int njobs, input int dmin, input int dmax,
                       input int inj_job, input logic [3:0] inj_mask, input int inj_cnt);
    int d;
    int w;
    for (int j = 0; j < njobs; j++) begin
      w = 0;
      while (sendSig !== 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (sendSig !== 1'b1) begin
        errors++;
        $display("FAIL serve_wait job %0d: sendSig=%b, want 1 within 100 cycles", j, sendSig);
        return;
      end
      obs_q.push_back({startAddr, endAddr, srcSel});
      obs_t.push_back(cyc);
      d = $urandom_range(dmax, dmin);
      for (int c = 0; c < d; c++) begin
        @(negedge clk);
        if (c == 0) begin
          checks++;
          if (sendSig !== 1'b0) begin
            errors++;
            $display("FAIL sendsig_width job %0d: sendSig=%b one cycle later, want 0", j, sendSig);
          end
        end
        if (j == inj_job && c < 2 * inj_cnt && (c % 2) == 0) set_req(inj_mask);
        else set_req(4'b0000);
      end
      set_req(4'b0000);
      sendOk = 1'b1;
      @(negedge clk);
      sendOk = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b, want 0 within 100 cycles", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(4'b0000);
    sendOk = 1'b0;
    clrErr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sendSig, startAddr, endAddr, srcSel, busy, pendMask, timeoutErr} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ss=%b sa=%h ea=%h src=%0d busy=%b pend=%b terr=%b, want all 0",
               sendSig, startAddr, endAddr, srcSel, busy, pendMask, timeoutErr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sendSig !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b sendSig=%b, want 0 0", busy, sendSig);
    end
  endtask

  task automatic test_single();
    set_req(4'b0001);
    @(negedge clk);
    set_req(4'b0000);
    checks++;
    if (pendMask !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_pend: pend=%b busy=%b, want 0001 0", pendMask, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sendSig !== 1'b0) begin
      errors++;
      $display("FAIL single_arb: busy=%b sendSig=%b, want 1 0", busy, sendSig);
    end
    @(negedge clk);
    checks++;
    if (pendMask !== 4'b0000 || sendSig !== 1'b0) begin
      errors++;
      $display("FAIL single_load: pend=%b sendSig=%b, want 0000 0", pendMask, sendSig);
    end
    @(negedge clk);
    checks++;
    if (sendSig !== 1'b1 || startAddr !== 16'h0000 || endAddr !== 16'h0000 || srcSel !== 2'd0) begin
      errors++;
      $display("FAIL single_send: ss=%b sa=%h ea=%h src=%0d, want 1 0000 0000 0",
               sendSig, startAddr, endAddr, srcSel);
    end
    repeat (10) @(negedge clk);
    sendOk = 1'b1;
    @(negedge clk);
    sendOk = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_next: busy=%b, want 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pendMask !== 4'b0000) begin
      errors++;
      $display("FAIL single_done: busy=%b pend=%b, want 0 0000", busy, pendMask);
    end
    model_last = 0;
  endtask

  task automatic test_cf_dump();
    clear_q();
    model_batch(4'b1000);
    pulse(4'b1000);
    serve(5, 5, 5, -1, 4'b0000, 0);
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL cf_count: got %0d jobs, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL cf_job %0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < obs_t.size(); i++) begin
      checks++;
      if (obs_t[i] - obs_t[i-1] != 8) begin
        errors++;
        $display("FAIL cf_spacing %0d: got %0d cycles, want 8", i, obs_t[i] - obs_t[i-1]);
      end
    end
  endtask

  task automatic test_all_four();
    logic [3:0] p;
    int g;
    bit inj;
    clear_q();
    p = 4'hF;
    inj = 0;
    while (p != 4'b0000) begin
      g = rr_pick(p, model_last);
      p[g] = 1'b0;
      model_last = g;
      model_push(g);
      if (g == 3 && !inj) begin
        p = 4'hF;
        inj = 1;
      end
    end
    pulse(4'hF);
    serve(exp_q.size(), 3, 8, 4, 4'hF, 1);
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL all4_count: got %0d jobs, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL all4_job %0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_coalesce();
    clear_q();
    model_batch(4'b0100);
    model_batch(4'b0010);
    pulse(4'b0100);
    serve(2, 10, 10, 0, 4'b0010, 3);
    wait_idle();
    model_batch(4'b0010);
    model_batch(4'b0010);
    set_req(4'b0010);
    @(negedge clk);
    set_req(4'b0000);
    @(negedge clk);
    set_req(4'b0010);
    @(negedge clk);
    set_req(4'b0000);
    checks++;
    if (pendMask !== 4'b0010) begin
      errors++;
      $display("FAIL coalesce_repend: pend=%b, want 0010", pendMask);
    end
    serve(2, 4, 9, -1, 4'b0000, 0);
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL coalesce_count: got %0d jobs, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL coalesce_job %0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pendMask !== 4'b0000) begin
      errors++;
      $display("FAIL coalesce_extra: busy=%b pend=%b, want 0 0000", busy, pendMask);
    end
  endtask

  task automatic test_random();
    logic [3:0] m;
    for (int it = 0; it < 6; it++) begin
      clear_q();
      m = 4'($urandom_range(15, 1));
      model_batch(m);
      pulse(m);
      serve(exp_q.size(), 2, 12, -1, 4'b0000, 0);
      wait_idle();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_count it%0d mask %b: got %0d jobs, want %0d", it, m, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_job it%0d #%0d: got %h, want %h", it, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int w;
    int n_ss;
    int n_busy;
    pulse(4'b1000);
    model_last = 3;
    w = 0;
    while (sendSig !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (sendSig !== 1'b1 || startAddr !== 16'h1000 || endAddr !== 16'h101F) begin
      errors++;
      $display("FAIL to_start: ss=%b sa=%h ea=%h, want 1 1000 101f", sendSig, startAddr, endAddr);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (timeoutErr !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early: terr=%b busy=%b after 14 WAIT cycles, want 0 1", timeoutErr, busy);
    end
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
    checks++;
    if (timeoutErr !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_fire: terr=%b busy=%b after 15 WAIT cycles with clrErr, want 1 0", timeoutErr, busy);
    end
    sendOk = 1'b1;
    @(negedge clk);
    sendOk = 1'b0;
    n_ss = 0;
    n_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (sendSig === 1'b1) n_ss++;
      if (busy === 1'b1) n_busy++;
    end
    checks++;
    if (n_ss != 0 || n_busy != 0 || pendMask !== 4'b0000) begin
      errors++;
      $display("FAIL to_dropped: sendSig pulses %0d busy cycles %0d pend=%b, want 0 0 0000", n_ss, n_busy, pendMask);
    end
    checks++;
    if (timeoutErr !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: terr=%b, want 1", timeoutErr);
    end
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
    checks++;
    if (timeoutErr !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: terr=%b, want 0", timeoutErr);
    end
    clear_q();
    model_batch(4'b0001);
    pulse(4'b0001);
    serve(1, 3, 6, -1, 4'b0000, 0);
    wait_idle();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL to_recover: got %0d jobs first %h, want 1 job %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 34'h0, exp_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int n_ss;
    int n_busy;
    clear_q();
    pulse(4'b1000);
    serve(2, 3, 3, -1, 4'b0000, 0);
    w = 0;
    while (sendSig !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (sendSig !== 1'b1 || startAddr !== 16'h3000 || endAddr !== 16'h307F) begin
      errors++;
      $display("FAIL rst_seg2: ss=%b sa=%h ea=%h, want 1 3000 307f", sendSig, startAddr, endAddr);
    end
    repeat (2) @(negedge clk);
    pulse(4'b0001);
    checks++;
    if (pendMask !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_prepend: pend=%b busy=%b, want 0001 1", pendMask, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sendSig, startAddr, endAddr, srcSel, busy, pendMask, timeoutErr} !== 41'd0) begin
      errors++;
      $display("FAIL rst_async: ss=%b sa=%h ea=%h src=%0d busy=%b pend=%b terr=%b, want all 0",
               sendSig, startAddr, endAddr, srcSel, busy, pendMask, timeoutErr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 3;
    n_ss = 0;
    n_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (sendSig === 1'b1) n_ss++;
      if (busy === 1'b1) n_busy++;
    end
    checks++;
    if (n_ss != 0 || n_busy != 0) begin
      errors++;
      $display("FAIL rst_quiet: sendSig pulses %0d busy cycles %0d, want 0 0", n_ss, n_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cf_dump();
    test_all_four();
    test_coalesce();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
